// File: rtl/stopwatch_pkg.sv
// Shared constants, run/pause state encoding and BCD digit type for the stopwatch core.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned SEC_ONES_MAX = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_ONES_MAX = 9;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } run_state_e;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// Single mod-(MAX+1) BCD digit counter with synchronous clear and wrap carry.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   inc,
  input  logic   clr_wrap,
  output digit_t q,
  output logic   carry
);

  digit_t q_q;
  digit_t q_d;
  logic   at_max;

  assign at_max = (q_q == DIGIT_W'(MAX));

  always_comb begin
    q_d = q_q;
    if (clr_wrap) begin
      q_d = '0;
    end else if (inc) begin
      q_d = at_max ? '0 : q_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & at_max;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch timekeeping core: 1 Hz counting, pause/resume, 2 Hz manual adjust.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] seconds1,
  output logic [3:0] seconds2,
  output logic [3:0] minutes1,
  output logic [3:0] minutes2,
  output logic       running,
  output logic       blink
);

  run_state_e state_q, state_d;
  logic       pause_prev_q, pause_prev_d;
  logic       running_q, running_d;
  logic       blink_q, blink_d;
  logic       pause_rise;

  logic inc_s1, inc_m1;
  logic carry_s1, carry_s2, carry_m1;
  logic carry_m2_unused;

  assign pause_rise = pause_btn & ~pause_prev_q;

  // Next state and registered status outputs; ticks act on the pre-toggle state.
  always_comb begin
    state_d      = state_q;
    pause_prev_d = pause_btn;
    running_d    = 1'b0;
    blink_d      = 1'b0;
    if (pause_rise) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
    running_d = (state_d == ST_RUN) & ~adj;
    if (adj) begin
      blink_d = blink_q ^ tick_2hz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pause_prev_q <= 1'b1;
      running_q    <= 1'b1;
      blink_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pause_prev_q <= pause_prev_d;
      running_q    <= running_d;
      blink_q      <= blink_d;
    end
  end

  // Adjust mode steers tick_2hz into the selected field and breaks the sec->min carry.
  always_comb begin
    inc_s1 = 1'b0;
    inc_m1 = 1'b0;
    if (adj) begin
      inc_s1 = tick_2hz & sel;
      inc_m1 = tick_2hz & ~sel;
    end else begin
      inc_s1 = tick_1hz & (state_q == ST_RUN);
      inc_m1 = carry_s2;
    end
  end

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk      (clk),
    .rst      (rst),
    .inc      (inc_s1),
    .clr_wrap (1'b0),
    .q        (seconds1),
    .carry    (carry_s1)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk      (clk),
    .rst      (rst),
    .inc      (carry_s1),
    .clr_wrap (1'b0),
    .q        (seconds2),
    .carry    (carry_s2)
  );

  bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk      (clk),
    .rst      (rst),
    .inc      (inc_m1),
    .clr_wrap (1'b0),
    .q        (minutes1),
    .carry    (carry_m1)
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk      (clk),
    .rst      (rst),
    .inc      (carry_m1),
    .clr_wrap (1'b0),
    .q        (minutes2),
    .carry    (carry_m2_unused)
  );

  assign running = running_q;
  assign blink   = blink_q;

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Timekeeping core of the stopwatch: holds the current MM:SS value as four BCD digits and advances it on a 1 Hz enable pulse. It supports pause/resume and a manual adjust mode that increments minutes or seconds at 2 Hz. It sits directly upstream of `displayDriver`: its four digit outputs connect one-to-one to that block's `seconds1`, `seconds2`, `minutes1` and `minutes2` inputs.

## Interface
Parameters:
- `MIN_TENS_MAX`, default 9: highest minutes-tens digit. Minutes wrap after `MIN_TENS_MAX`9; the default gives 99.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `tick_1hz` in 1: one-cycle enable pulse, once per second.
- `tick_2hz` in 1: one-cycle enable pulse, twice per second.
- `pause_btn` in 1: debounced, synchronized level. Each rising edge toggles run/pause.
- `adj` in 1: level; 1 selects adjust mode.
- `sel` in 1: adjust target; 0 = minutes, 1 = seconds.
- `seconds1` out 4: seconds ones digit, BCD 0–9.
- `seconds2` out 4: seconds tens digit, BCD 0–5.
- `minutes1` out 4: minutes ones digit, BCD 0–9.
- `minutes2` out 4: minutes tens digit, BCD 0–`MIN_TENS_MAX`.
- `running` out 1: 1 when counting in normal mode.
- `blink` out 1: 2 Hz toggle while `adj`=1; the display uses it to flash the selected field.

## Operation
- **Reset values:** all digits 0; state RUN; `running`=1; `blink`=0. The internal `pause_prev` register resets to 1, so a button held through reset does not toggle.
- **Run/pause state machine** (states RUN and PAUSED):
  - `pause_rise = pause_btn & ~pause_prev`.
  - `pause_rise` toggles RUN↔PAUSED. This is evaluated in every mode, including adjust.
- **Normal mode** (`adj`=0): in RUN, `tick_1hz` increments MM:SS.
  - Carry chain: `seconds1` 9→0 carries into `seconds2`; `seconds2` 5→0 carries into `minutes1`; `minutes1` 9→0 carries into `minutes2`; `minutes2` at `MIN_TENS_MAX` wraps to 0.
  - Default wrap: 99:59 → 00:00.
  - In PAUSED, ticks are ignored.
- **Adjust mode** (`adj`=1): `tick_1hz` is ignored regardless of state. `tick_2hz` increments the selected field by 1:
  - `sel`=1: seconds wrap 59→00 with no carry into minutes.
  - `sel`=0: minutes wrap (`MIN_TENS_MAX`9)→00; seconds are untouched.
- **`running`** = (state==RUN) & ~`adj`.
- **`blink`:** toggles on each `tick_2hz` while `adj`=1; forced to 0 on the cycle after `adj`=0 is sampled.
- **Invalid digits:** not reachable; no recovery logic is required.

## Timing
- All outputs are registered. A tick sampled high at edge N produces updated digits after edge N, so latency is 1 cycle.
- If `pause_rise` and `tick_1hz` occur in the same cycle, the tick is processed using the pre-toggle state:
  - RUN with tick: count increments, then the state becomes PAUSED.
  - PAUSED with tick: no increment, then the state becomes RUN.
- If `tick_1hz` and `tick_2hz` coincide in adjust mode, only the `tick_2hz` action occurs.
- A change of `adj` or `sel` takes effect for ticks sampled on the same edge.
- Asserting `rst` mid-count clears all outputs immediately, without waiting for a clock edge. Counting resumes on the first tick after release.

## Structure
- **Shared package `stopwatch_pkg`:** holds the constants `SEC_ONES_MAX`=9, `SEC_TENS_MAX`=5, `MIN_ONES_MAX`=9, the RUN/PAUSED state encoding, and the BCD digit type (4 bits).
- **Sub-module `bcd_digit`:** one mod-N BCD digit counter, parameter `MAX`, with inputs `clk`, `rst`, `inc`, `clr_wrap`, and outputs `q` and `carry` (carry = `inc` & `q`==`MAX`). Four instances are chained.
  - In adjust mode, the carry from `seconds2` into `minutes1` is gated off.
  - The `minutes1` increment is sourced from `tick_2hz` when `sel`=0.

## Test plan
- **Reset and count:** reset, then 75 `tick_1hz` pulses → digits read 01:15 and `running`=1.
- **Full wrap:** preload to 99:58 via adjust, then return to normal mode and send 2 ticks → 00:00.
- **Pause:** pulse `pause_btn`, then 10 ticks → value unchanged and `running`=0. A second rising edge plus 1 tick → value +1.
- **Same-cycle pause and tick in RUN:** at 00:05 → 00:06 and PAUSED. Hold `pause_btn` high through reset → no toggle; state stays RUN.
- **Adjust seconds:** `adj`=1, `sel`=1 from 00:58 with 3 `tick_2hz` → 00:01, minutes still 00. `blink` toggles 3 times, and `tick_1hz` pulses cause no change.
- **Asynchronous reset mid-count:** assert `rst` between clock edges at 12:34 → all digits 0 before the next edge, and `blink`=0.
